// File: rtl/ipsxe_floating_point_invsqrt_horner_v1_0_if.sv
// ipsxe_floating_point_invsqrt_horner_v1_0_if: operand/coefficient/result handshake bundle for the Horner evaluator
interface ipsxe_floating_point_invsqrt_horner_v1_0_if #(parameter int DX_W = 16);
   logic                i_valid;
   logic                o_ready;
   logic [8+DX_W-1:0]   i_x;
   logic [7:0]          o_x_hi8;
   logic [2:0]          o_coef_sel;
   logic [21:0]         i_coef;
   logic                o_valid;
   logic                i_ready;
   logic [21:0]         o_y;
   modport slave (input i_valid, i_x, i_coef, i_ready, output o_ready, o_x_hi8, o_coef_sel, o_valid, o_y);
   modport master (output i_valid, i_x, i_coef, i_ready, input o_ready, o_x_hi8, o_coef_sel, o_valid, o_y);
endinterface

// File: rtl/ipsxe_floating_point_invsqrt_horner_v1_0.sv
// ipsxe_floating_point_invsqrt_horner_v1_0: sequential Horner evaluation of a 6th-order Taylor polynomial; IPSXE_FLOATING_POINT_INVSQRT_HORNER_SAT_EN enables output saturation
module ipsxe_floating_point_invsqrt_horner_v1_0 #(
   parameter int DX_W = 16
) (
   input logic i_clk,
   input logic i_rst,
   ipsxe_floating_point_invsqrt_horner_v1_0_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
   state_t                   state_q, state_d;
   logic [25:0]              acc_q, acc_d;
   logic [2:0]               k_q, k_d;
   logic [7:0]               x_hi8_q, x_hi8_d;
   logic [DX_W-1:0]          dx_q, dx_d;
   logic [21:0]              y_q, y_d;
   logic [2:0]               coef_sel;
   logic signed [25+DX_W:0]  prod;
   logic [25:0]              step;
   logic [21:0]              y_step;
   assign prod = $signed(acc_q) * $signed({1'b0, dx_q});
   assign step = {4'b0, bus.i_coef} - 26'(prod >>> DX_W);
`ifdef IPSXE_FLOATING_POINT_INVSQRT_HORNER_SAT_EN
   assign y_step = step[25] ? 22'h000000 : (|step[24:22] ? 22'h3FFFFF : step[21:0]);
`else
   assign y_step = step[21:0];
`endif
   assign bus.o_ready    = state_q == IDLE;
   assign bus.o_valid    = state_q == DONE;
   assign bus.o_x_hi8    = x_hi8_q;
   assign bus.o_coef_sel = coef_sel;
   assign bus.o_y        = y_q;
   // next-state: capture operand, load a6, iterate k=5..0, then hold the result until taken
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      k_d      = k_q;
      x_hi8_d  = x_hi8_q;
      dx_d     = dx_q;
      y_d      = y_q;
      coef_sel = 3'd0;
      case (state_q)
         IDLE: if (bus.i_valid) begin
            x_hi8_d = bus.i_x[8+DX_W-1:DX_W];
            dx_d    = bus.i_x[DX_W-1:0];
            state_d = LOAD;
         end
         LOAD: begin
            coef_sel = 3'd6;
            acc_d    = {4'b0, bus.i_coef};
            k_d      = 3'd5;
            state_d  = ITER;
         end
         ITER: begin
            coef_sel = k_q;
            acc_d    = step;
            k_d      = k_q == 3'd0 ? k_q : k_q - 3'd1;
            state_d  = k_q == 3'd0 ? DONE : ITER;
            y_d      = k_q == 3'd0 ? y_step : y_q;
         end
         DONE: state_d = bus.i_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers, cleared asynchronously
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         k_q     <= '0;
         x_hi8_q <= '0;
         dx_q    <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         x_hi8_q <= x_hi8_d;
         dx_q    <= dx_d;
         y_q     <= y_d;
      end
   end
endmodule
